// File: rtl/snes_reader_pkg.sv
// rtl/snes_reader_pkg.sv - shared SNES reader types and button code constants
//
// Purpose: FSM state encoding, frame geometry and the 4-bit button codes
// that the grid controller consumes on its controller_in input.
// Ports: none (package).

package snes_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  // The pad shifts 16 bits per frame; only the first 12 are real buttons.
  localparam int NUM_BUTTONS = 12;
  localparam int NUM_BITS    = 16;

  localparam logic [3:0] BTN_NONE   = 4'd0;
  localparam logic [3:0] BTN_B      = 4'd1;
  localparam logic [3:0] BTN_Y      = 4'd2;
  localparam logic [3:0] BTN_SELECT = 4'd3;
  localparam logic [3:0] BTN_START  = 4'd4;
  localparam logic [3:0] BTN_UP     = 4'd5;
  localparam logic [3:0] BTN_DOWN   = 4'd6;
  localparam logic [3:0] BTN_LEFT   = 4'd7;
  localparam logic [3:0] BTN_RIGHT  = 4'd8;
  localparam logic [3:0] BTN_A      = 4'd9;
  localparam logic [3:0] BTN_X      = 4'd10;
  localparam logic [3:0] BTN_L      = 4'd11;
  localparam logic [3:0] BTN_R      = 4'd12;

  // Button codes are the 1-based mask bit position.
  function automatic logic [3:0] btn_code_of(input int idx);
    return 4'(idx + 1);
  endfunction

endpackage

// File: rtl/snes_priority_enc.sv
// rtl/snes_priority_enc.sv - 12-bit button mask to 4-bit button code encoder
//
// Purpose: combinational priority encoder; the lowest-numbered pressed
// button wins, an empty mask yields BTN_NONE.
// Ports:
//   mask  in  12  pressed mask, 1 = pressed
//   code  out 4   1-based index of the lowest set bit, 0 when none

module snes_priority_enc
  import snes_reader_pkg::*;
(
  input  logic [NUM_BUTTONS-1:0] mask,
  output logic [3:0]             code
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    code = BTN_NONE;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (mask[i]) code = btn_code_of(i);
    end
  end

endmodule

// File: rtl/snes_reader.sv
// rtl/snes_reader.sv - SNES controller poller producing a button mask and code
//
// Purpose: every POLL_CYCLES clocks, latch the pad, clock out 16 bits with a
// HALF_BIT-cycle half period, sample each bit at the end of its low phase
// and publish the 12 button bits plus a priority-encoded code.
// Optional feature: define SNES_READER_DEBOUNCE_EN to publish a mask only
// when two consecutive frames agree.
// Ports:
//   clk          in  1   system clock
//   reset        in  1   synchronous active-high reset
//   snes_data    in  1   pad serial data, active-low, asynchronous
//   snes_latch   out 1   pad latch pulse, active-high
//   snes_clk     out 1   pad shift clock, idles high
//   buttons      out 12  pressed mask (bit0=B .. bit11=R), 1 = pressed
//   button_code  out 4   1-based lowest pressed button, 0 = none
//   frame_valid  out 1   one-cycle pulse at the end of every frame

module snes_reader
  import snes_reader_pkg::*;
#(
  parameter int HALF_BIT    = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   snes_data,
  output logic                   snes_latch,
  output logic                   snes_clk,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic [3:0]             button_code,
  output logic                   frame_valid
);

  localparam int POLL_W = $clog2(POLL_CYCLES);
  localparam int TMR_W  = $clog2(2 * HALF_BIT);

  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [TMR_W-1:0]  HALF_LAST  = TMR_W'(HALF_BIT - 1);
  localparam logic [TMR_W-1:0]  LATCH_LAST = TMR_W'(2 * HALF_BIT - 1);
  localparam logic [3:0]        LAST_BIT   = 4'(NUM_BITS - 1);

  state_t                 state, state_next;
  logic [POLL_W-1:0]      poll_cnt;
  logic [TMR_W-1:0]       timer;
  logic [3:0]             bit_idx;
  logic                   data_meta, data_sync;
  logic [NUM_BUTTONS-1:0] frame_mask;
  logic [3:0]             frame_code;
  logic                   poll_wrap;
  logic                   half_end;

  assign poll_wrap = (poll_cnt == POLL_LAST);
  assign half_end  = (timer == HALF_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_meta <= 1'b0;
      data_sync <= 1'b0;
    end else begin
      data_meta <= snes_data;
      data_sync <= data_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || poll_wrap) poll_cnt <= '0;
    else                    poll_cnt <= poll_cnt + 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (poll_wrap) state_next = ST_LATCH;
      ST_LATCH: if (timer == LATCH_LAST) state_next = ST_LOW;
      ST_LOW:   if (half_end) state_next = ST_HIGH;
      ST_HIGH:  if (half_end) state_next = (bit_idx == LAST_BIT) ? ST_DONE : ST_LOW;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs are pure functions of the state.
  always_comb begin
    snes_latch  = (state == ST_LATCH);
    snes_clk    = (state != ST_LOW);
    frame_valid = (state == ST_DONE);
  end

  // Phase timer restarts on every state change so each phase counts from 0.
  always_ff @(posedge clk) begin
    if (reset || (state != state_next)) timer <= '0;
    else                                timer <= timer + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx    <= '0;
      frame_mask <= '0;
    end else begin
      if (state == ST_LATCH) bit_idx <= '0;
      else if (state == ST_HIGH && half_end && bit_idx != LAST_BIT)
        bit_idx <= bit_idx + 1'b1;
      // Sample just before snes_clk rises; bits 12..15 are clocked but dropped.
      if (state == ST_LOW && half_end && bit_idx < 4'(NUM_BUTTONS))
        frame_mask[bit_idx] <= ~data_sync;
    end
  end

  snes_priority_enc u_enc (
    .mask (frame_mask),
    .code (frame_code)
  );

`ifdef SNES_READER_DEBOUNCE_EN
  logic [NUM_BUTTONS-1:0] candidate;

  always_ff @(posedge clk) begin
    if (reset) begin
      candidate   <= '0;
      buttons     <= '0;
      button_code <= BTN_NONE;
    end else if (state == ST_DONE) begin
      candidate <= frame_mask;
      if (frame_mask == candidate) begin
        buttons     <= frame_mask;
        button_code <= frame_code;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      buttons     <= '0;
      button_code <= BTN_NONE;
    end else if (state == ST_DONE) begin
      buttons     <= frame_mask;
      button_code <= frame_code;
    end
  end
`endif

endmodule

// File: tb/tb_snes_reader.sv
// tb/tb_snes_reader.sv - scoreboard testbench for snes_reader

module tb_snes_reader;

  localparam int HB   = 4;
  localparam int POLL = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        snes_data;
  logic        snes_latch;
  logic        snes_clk;
  logic [11:0] buttons;
  logic [3:0]  button_code;
  logic        frame_valid;

  int checks = 0;
  int errors = 0;

  logic [15:0] pat = 16'h0000;
  logic [15:0] exp_q[$];
  logic [11:0] cand_m = '0;
  logic [11:0] last_m = '0;
  logic [3:0]  last_c = '0;

  always #5 clk = ~clk;

  snes_reader #(.HALF_BIT(HB), .POLL_CYCLES(POLL)) dut (
    .clk         (clk),
    .reset       (reset),
    .snes_data   (snes_data),
    .snes_latch  (snes_latch),
    .snes_clk    (snes_clk),
    .buttons     (buttons),
    .button_code (button_code),
    .frame_valid (frame_valid)
  );

  // Pad model: latch reloads bit 0, each snes_clk rising edge advances.
  int  pad_idx = 0;
  logic prev_sclk = 1'b1;
  always @(negedge clk) begin
    if (snes_latch) pad_idx = 0;
    else if (snes_clk && !prev_sclk && pad_idx < 16) pad_idx = pad_idx + 1;
    prev_sclk = snes_clk;
    snes_data = (pad_idx < 16) ? ~pat[pad_idx] : 1'b1;
  end

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: outputs are valid the cycle after the frame_valid pulse.
  always @(negedge clk) begin
    if (!reset && frame_valid) begin
      logic [15:0] e;
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("buttons", int'(buttons), int'(e[15:4]));
        check("button_code", int'(button_code), int'(e[3:0]));
      end
    end
  end

  task automatic push_frame(input logic [11:0] m, input logic [3:0] c);
`ifdef SNES_READER_DEBOUNCE_EN
    if (m == cand_m) begin
      last_m = m;
      last_c = c;
    end
    cand_m = m;
    exp_q.push_back({last_m, last_c});
`else
    exp_q.push_back({m, c});
`endif
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!frame_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!frame_valid) check("frame_timeout", 0, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] p, input logic [11:0] m, input logic [3:0] c);
    pat = p;
    push_frame(m, c);
    wait_frame();
  endtask

  // Counts negedges after reset release until snes_latch is seen high.
  task automatic latch_delay(output int n);
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (snes_latch) break;
    end
  endtask

  initial begin
    int n;
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_buttons", int'(buttons), 0);
    check("rst_code", int'(button_code), 0);
    check("rst_latch", int'(snes_latch), 0);
    check("rst_sclk", int'(snes_clk), 1);
    check("rst_fvalid", int'(frame_valid), 0);
    reset = 1'b0;
    pat = 16'h0000;
    push_frame(12'h000, 4'd0);

    latch_delay(n);
    check("latch_delay", n, POLL);
    w = 1;
    while (snes_latch && w < 100) begin
      @(negedge clk);
      if (snes_latch) w++;
    end
    check("latch_width", w, 2 * HB);
    for (int i = 0; i < 16; i++) begin
      n = 0;
      while (snes_clk && n < 100) begin
        @(negedge clk);
        n++;
      end
      w = 0;
      while (!snes_clk && w < 100) begin
        w++;
        @(negedge clk);
      end
      check($sformatf("sclk_low_%0d", i), w, HB);
    end
    wait_frame();

    run_frame(16'h0080, 12'h080, 4'd8);
    run_frame(16'h00C0, 12'h0C0, 4'd7);
    run_frame(16'h0088, 12'h088, 4'd4);
    run_frame(16'hF000, 12'h000, 4'd0);
    run_frame(16'h0001, 12'h001, 4'd1);
    run_frame(16'h0800, 12'h800, 4'd12);
    run_frame(16'h0FFF, 12'hFFF, 4'd1);
    run_frame(16'h0000, 12'h000, 4'd0);
    run_frame(16'h0000, 12'h000, 4'd0);

    // Reset during bit 5 with A pressed.
    pat = 16'h0100;
    n = 0;
    while (!snes_latch && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("latch_seen", int'(snes_latch), 1);
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (snes_clk && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (i < 5) begin
        n = 0;
        while (!snes_clk && n < 100) begin
          @(negedge clk);
          n++;
        end
      end
    end
    check("bit5_low", int'(snes_clk), 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_sclk", int'(snes_clk), 1);
    check("abort_latch", int'(snes_latch), 0);
    check("abort_buttons", int'(buttons), 0);
    check("abort_code", int'(button_code), 0);
    reset = 1'b0;
    cand_m = '0;
    last_m = '0;
    last_c = '0;
    pat = 16'h0000;
    latch_delay(n);
    check("relatch_delay", n, POLL);
    check("abort_hold", int'(buttons), 0);
    push_frame(12'h000, 4'd0);
    wait_frame();

    run_frame(16'h0080, 12'h080, 4'd8);
    run_frame(16'h0040, 12'h040, 4'd7);
    run_frame(16'h0040, 12'h040, 4'd7);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
